// File: rtl/inst_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the SRAM-style memory (slave).
// inst_req/inst_addr are held until inst_addr_ok; inst_data_ok/inst_rdata return one word per accepted request.
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_WIDTH-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one memory read per PC, flush cancellation, misaligned-PC address errors,
// and a one-entry output buffer handed to decode with valid/ready (transfer when inst_valid & inst_ready).
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  pc_en,
  inst_fetch_if.master          mem,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_adel_o,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    CANCEL = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  cancel, cancel_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  buf_free;
  logic                  start;
  logic                  misaligned;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [ADDR_WIDTH-1:0] load_pc;
  logic                  load_adel;

  assign buf_free   = !inst_valid || inst_ready;
  assign misaligned = (pc[1:0] != 2'b00);
  // A new fetch only starts when the buffer will be empty by the time its word can return.
  assign start      = (state == IDLE) && !rst && !flush && buf_free;
  assign pc_en      = start;

  assign mem.inst_req  = (state == REQ);
  assign mem.inst_addr = addr_q;
  assign dbg_state     = state;

  always_comb begin
    state_nxt  = state;
    cancel_nxt = cancel;
    addr_nxt   = addr_q;
    load       = 1'b0;
    load_data  = '0;
    load_pc    = pc;
    load_adel  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!misaligned) begin
            addr_nxt  = pc;
            state_nxt = REQ;
          end else begin
            load      = 1'b1;
            load_adel = 1'b1;
          end
        end
      end
      REQ: begin
        // The request stays up through a flush; the flush is remembered and the word dropped later.
        if (mem.inst_addr_ok) begin
          if (flush || cancel) begin
            state_nxt  = CANCEL;
            cancel_nxt = 1'b1;
          end else begin
            state_nxt  = WAIT;
          end
        end else if (flush) begin
          cancel_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (mem.inst_data_ok) begin
          state_nxt = IDLE;
          if (!flush) begin
            load      = 1'b1;
            load_data = mem.inst_rdata;
            load_pc   = addr_q;
          end
        end else if (flush) begin
          state_nxt  = CANCEL;
          cancel_nxt = 1'b1;
        end
      end
      CANCEL: begin
        if (mem.inst_data_ok) begin
          cancel_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cancel <= 1'b0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      cancel <= cancel_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid  <= 1'b0;
      inst_o      <= '0;
      inst_pc_o   <= '0;
      inst_adel_o <= 1'b0;
    end else if (flush) begin
      inst_valid  <= 1'b0;
    end else if (load) begin
      inst_valid  <= 1'b1;
      inst_o      <= load_data;
      inst_pc_o   <= load_pc;
      inst_adel_o <= load_adel;
    end else if (inst_ready) begin
      inst_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed test-plan scenarios followed by randomized flush/stall/memory-latency traffic,
// checked each cycle against a transaction-level model of fetched instructions.
module tb_inst_fetch;

  localparam int W = 65;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inst_ready = 1'b1;
  logic [31:0] new_pc = 32'h0;
  logic [31:0] pc_reg = 32'hbfc00000;
  logic [31:0] pc;
  logic        pc_en;
  logic        inst_valid;
  logic        inst_adel_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [1:0]  dbg_state;

  inst_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

  inst_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .flush       (flush),
    .pc_en       (pc_en),
    .mem         (mem),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .inst_adel_o (inst_adel_o),
    .dbg_state   (dbg_state)
  );

  // PC register as the surrounding pipeline builds it: flush muxes new_pc straight through.
  assign pc = flush ? new_pc : pc_reg;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / knobs ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int aok_pct = 100;
  int rdy_pct = 100;
  int flush_pct = 0;
  int max_delay = 0;
  int hold_cnt = 0;
  logic        force_flush = 1'b0;
  logic [31:0] force_pc = 32'h0;
  logic        live_en = 1'b0;

  // ---------------- model state ----------------
  logic [W-1:0] exp_q[$];
  logic         pc_en_s = 1'b0;
  logic         busy = 1'b0;
  logic [31:0]  fetch_addr = 32'h0;
  logic         req_hold_prev = 1'b0;
  logic [31:0]  addr_prev = 32'h0;
  int           idle_cnt = 0;
  logic         mem_pending = 1'b0;
  logic [31:0]  mem_addr = 32'h0;
  int           mem_delay = 0;
  logic         data_ok_n = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h24080001;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] p;
    p = 32'hbfc00000 + ($urandom_range(0, 255) << 2);
    if ($urandom_range(0, 5) == 0) p = p + $urandom_range(1, 3);
    return p;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: inputs change #1 after the active edge ----------------
  always @(posedge clk) begin
    #1;
    if (flush) pc_reg = new_pc;
    else if (pc_en_s) pc_reg = pc_reg + 32'd4;
    mem.inst_data_ok = data_ok_n;
    mem.inst_rdata   = data_ok_n ? word(mem_addr) : $urandom();
    mem.inst_addr_ok = mem.inst_req && (hold_cnt == 0) && ($urandom_range(0, 99) < aok_pct);
    if (mem.inst_req && hold_cnt > 0) hold_cnt--;
    inst_ready = ($urandom_range(0, 99) < rdy_pct);
    if (force_flush) begin
      flush       = 1'b1;
      new_pc      = force_pc;
      force_flush = 1'b0;
    end else begin
      flush = ($urandom_range(0, 99) < flush_pct);
      if (flush) new_pc = pick_pc();
    end
  end

  // ---------------- model + compare, sampled on the falling edge ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pc_en_s       = 1'b0;
      busy          = 1'b0;
      req_hold_prev = 1'b0;
      mem_pending   = 1'b0;
      data_ok_n     = 1'b0;
      idle_cnt      = 0;
    end else begin
      pc_en_s = pc_en;
      if (req_hold_prev)
        chk("req_hold", 96'({mem.inst_req, mem.inst_addr}), 96'({1'b1, addr_prev}));
      req_hold_prev = mem.inst_req && !mem.inst_addr_ok;
      addr_prev     = mem.inst_addr;
      if (pc_en)
        chk("pc_en_legal", 96'({flush, busy, inst_valid && !inst_ready}), 96'(3'b000));
      if (mem.inst_req)
        chk("req_addr", 96'({busy, mem.inst_addr}), 96'({1'b1, fetch_addr}));
      if (inst_valid)
        chk("valid_has_item", 96'(exp_q.size() > 0), 96'(1));
      // Flush kills everything fetched so far, whether in flight or buffered.
      if (flush) exp_q.delete();
      else if (inst_valid && inst_ready && exp_q.size() > 0)
        chk("handoff", 96'({inst_adel_o, inst_pc_o, inst_o}), 96'(exp_q.pop_front()));
      if (mem.inst_data_ok) busy = 1'b0;
      if (pc_en) begin
        if (pc[1:0] == 2'b00) begin
          busy       = 1'b1;
          fetch_addr = pc;
          exp_q.push_back({1'b0, pc, word(pc)});
        end else begin
          exp_q.push_back({1'b1, pc, 32'h0});
        end
      end
      if (pc_en) idle_cnt = 0;
      else idle_cnt++;
      if (live_en) chk("liveness", 96'(idle_cnt <= 200), 96'(1));
      // Memory: one outstanding read, data no earlier than the cycle after acceptance.
      if (mem.inst_data_ok) mem_pending = 1'b0;
      if (mem.inst_req && mem.inst_addr_ok) begin
        mem_pending = 1'b1;
        mem_addr    = mem.inst_addr;
        mem_delay   = $urandom_range(0, max_delay);
      end else if (mem_pending && mem_delay > 0) begin
        mem_delay--;
      end
      data_ok_n = mem_pending && (mem_delay == 0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int   lat;
    logic found;
    int   run, max_run, pe_cnt, rq_cnt, v_cnt, chg_cnt;
    logic [31:0] saved;

    mem.inst_addr_ok = 1'b0;
    mem.inst_data_ok = 1'b0;
    mem.inst_rdata   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   96'(mem.inst_req),  96'(0));
    chk("rst_addr",  96'(mem.inst_addr), 96'(0));
    chk("rst_pc_en", 96'(pc_en),         96'(0));
    chk("rst_valid", 96'(inst_valid),    96'(0));
    chk("rst_inst",  96'(inst_o),        96'(0));
    chk("rst_pc_o",  96'(inst_pc_o),     96'(0));
    chk("rst_adel",  96'(inst_adel_o),   96'(0));
    chk("rst_state", 96'(dbg_state),     96'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // First fetch from the boot vector with zero-wait memory.
    found = 1'b0;
    lat   = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1'b1;
        lat   = c;
        break;
      end
    end
    chk("first_found",   96'(found),       96'(1));
    chk("first_latency", 96'(lat),         96'(3));
    chk("first_inst",    96'(inst_o),      96'(32'h24080001));
    chk("first_pc",      96'(inst_pc_o),   96'(32'hbfc00000));
    chk("first_adel",    96'(inst_adel_o), 96'(0));

    // Address acceptance withheld for 4 cycles: request held for 5 cycles.
    for (int c = 0; c < 10 && mem.inst_req; c++) @(negedge clk);
    hold_cnt = 4;
    run = 0;
    max_run = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem.inst_req) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
    chk("hold_run", 96'(max_run), 96'(5));

    // Decode stalls with the buffer full: fetching must stop and the word must hold.
    rdy_pct = 0;
    repeat (15) @(negedge clk);
    saved = inst_o;
    pe_cnt = 0; rq_cnt = 0; v_cnt = 0; chg_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pc_en) pe_cnt++;
      if (mem.inst_req) rq_cnt++;
      if (inst_valid) v_cnt++;
      if (inst_o !== saved) chg_cnt++;
    end
    chk("stall_pc_en", 96'(pe_cnt),  96'(0));
    chk("stall_req",   96'(rq_cnt),  96'(0));
    chk("stall_valid", 96'(v_cnt),   96'(8));
    chk("stall_hold",  96'(chg_cnt), 96'(0));
    rdy_pct = 100;
    repeat (5) @(negedge clk);

    // Flush to a misaligned PC: address-error entry, no memory access.
    force_pc = 32'hbfc00002;
    force_flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("adel_found", 96'(found),       96'(1));
    chk("adel_pc",    96'(inst_pc_o),   96'(32'hbfc00002));
    chk("adel_flag",  96'(inst_adel_o), 96'(1));
    chk("adel_inst",  96'(inst_o),      96'(0));

    // Flush to an aligned exception vector: next delivered word comes from there.
    force_pc = 32'hbfc00380;
    force_flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("vec_found", 96'(found),       96'(1));
    chk("vec_pc",    96'(inst_pc_o),   96'(32'hbfc00380));
    chk("vec_inst",  96'(inst_o),      96'(32'hfc7f0380));
    chk("vec_adel",  96'(inst_adel_o), 96'(0));

    // Randomized traffic: memory latency, acceptance delay, decode stalls, flushes.
    live_en = 1'b1;
    for (int seg = 0; seg < 15; seg++) begin
      aok_pct   = $urandom_range(30, 100);
      rdy_pct   = $urandom_range(20, 100);
      flush_pct = $urandom_range(0, 15);
      max_delay = $urandom_range(0, 3);
      repeat (200) @(negedge clk);
    end
    live_en   = 1'b0;
    flush_pct = 0;
    rdy_pct   = 100;
    aok_pct   = 100;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
